// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with dark gaps between digits and frame-synchronous data commit.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading-zero digits above digit 0.
module seg_scan_ctrl #(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  dig_sel,
   output logic [7:0]  led_seg,
   output logic        frame_done
);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   localparam logic [20:0] SHOW_LAST  = 21'(CLK_DIV - 1);
   localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYC - 1);

   logic [1:0]  state_r, state_s;
   logic [2:0]  idx_r, idx_s;
   logic [20:0] show_cnt_r, show_cnt_s;
   logic [7:0]  blank_cnt_r, blank_cnt_s;
   logic [31:0] pend_r, disp_r, disp_s;
   logic [7:0]  mask_r;
   logic [7:0]  dig_sel_r, dig_sel_s;
   logic [7:0]  led_seg_r, led_seg_s;
   logic        frame_done_r, frame_s, commit_s;
   logic [3:0]  above_s;
   logic [3:0]  nib_s;
   logic        data_wr_s, mask_wr_s;

   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         4'hF: seg = 8'h71;
         default: seg = 8'h00;
      endcase
      return seg;
   endfunction

   // Returns {found, index} of the lowest enabled digit strictly above cur
   function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
      logic [3:0] res;
      res = 4'h0;
      for (int i = 7; i >= 0; i--) begin
         res = (m[i] && (3'(i) > cur)) ? {1'b1, 3'(i)} : res;
      end
      return res;
   endfunction

   function automatic logic [2:0] lowest_en(input logic [7:0] m);
      logic [2:0] res;
      res = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         res = m[i] ? 3'(i) : res;
      end
      return res;
   endfunction

   assign data_wr_s  = we && (addr == 2'd0);
   assign mask_wr_s  = we && (addr == 2'd1);
   assign dig_sel    = dig_sel_r;
   assign led_seg    = led_seg_r;
   assign frame_done = frame_done_r;

   // Scan sequencing: slot timing and next-digit decision
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      show_cnt_s  = show_cnt_r;
      blank_cnt_s = blank_cnt_r;
      frame_s     = 1'b0;
      commit_s    = 1'b0;
      above_s     = next_above(mask_r, idx_r);
      case (state_r)
         ST_OFF: begin
            if (mask_r != 8'h00) begin
               state_s     = ST_BLANK;
               idx_s       = lowest_en(mask_r);
               blank_cnt_s = 8'h00;
            end else begin
               state_s = ST_OFF;
            end
         end
         ST_BLANK: begin
            if (blank_cnt_r == BLANK_LAST) begin
               blank_cnt_s = 8'h00;
               show_cnt_s  = 21'h0;
               state_s     = (mask_r == 8'h00) ? ST_OFF : ST_SHOW;
            end else begin
               blank_cnt_s = blank_cnt_r + 8'h01;
            end
         end
         ST_SHOW: begin
            if (show_cnt_r != SHOW_LAST) begin
               show_cnt_s = show_cnt_r + 21'h1;
            end else if (mask_r == 8'h00) begin
               show_cnt_s = 21'h0;
               state_s    = ST_OFF;
            end else if (above_s[3]) begin
               show_cnt_s  = 21'h0;
               blank_cnt_s = 8'h00;
               state_s     = ST_BLANK;
               idx_s       = above_s[2:0];
            end else begin
               // Wrap: frame boundary, new display data takes effect here
               show_cnt_s  = 21'h0;
               blank_cnt_s = 8'h00;
               state_s     = ST_BLANK;
               idx_s       = lowest_en(mask_r);
               frame_s     = 1'b1;
               commit_s    = 1'b1;
            end
         end
         default: begin
            state_s     = ST_BLANK;
            idx_s       = 3'd0;
            show_cnt_s  = 21'h0;
            blank_cnt_s = 8'h00;
         end
      endcase
   end

   // Display data update and next-cycle digit/segment drive
   always_comb begin
      if ((state_r == ST_OFF) || commit_s) begin
         disp_s = data_wr_s ? wdata : pend_r;
      end else begin
         disp_s = disp_r;
      end
      nib_s = disp_s[{idx_s, 2'b00} +: 4];
      if (state_s == ST_SHOW) begin
         dig_sel_s = 8'h01 << idx_s;
`ifdef SEG_LEADING_ZERO_BLANK_EN
         if ((idx_s != 3'd0) && ((disp_s >> {idx_s, 2'b00}) == 32'h0000_0000)) begin
            led_seg_s = 8'h00;
         end else begin
            led_seg_s = seg_decode(nib_s);
         end
`else
         led_seg_s = seg_decode(nib_s);
`endif
      end else begin
         dig_sel_s = 8'h00;
         led_seg_s = 8'h00;
      end
   end

   // Register readback
   always_comb begin
      case (addr)
         2'd0:    rdata = pend_r;
         2'd1:    rdata = {24'h00_0000, mask_r};
         2'd2:    rdata = {26'h000_0000, state_r, 1'b0, idx_r};
         default: rdata = 32'h0000_0000;
      endcase
   end

   // State, registers and registered display outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_BLANK;
         idx_r        <= 3'd0;
         show_cnt_r   <= 21'h0;
         blank_cnt_r  <= 8'h00;
         pend_r       <= 32'hDEAD_BEEF;
         disp_r       <= 32'hDEAD_BEEF;
         mask_r       <= 8'hFF;
         dig_sel_r    <= 8'h00;
         led_seg_r    <= 8'h00;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         show_cnt_r   <= show_cnt_s;
         blank_cnt_r  <= blank_cnt_s;
         pend_r       <= data_wr_s ? wdata : pend_r;
         disp_r       <= disp_s;
         mask_r       <= mask_wr_s ? wdata[7:0] : mask_r;
         dig_sel_r    <= dig_sel_s;
         led_seg_r    <= led_seg_s;
         frame_done_r <= frame_s;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl (CLK_DIV=4, BLANK_CYC=2): table of per-slot expectations
// plus hand-written sequences for OFF entry/exit and reset during a lit digit.
module tb_seg_scan_ctrl;

   typedef struct {
      logic [7:0]  dig;
      logic [7:0]  led;
      logic        fd;
      logic [2:0]  idx;
      logic        wr;
      logic [1:0]  wa;
      logic [31:0] wd;
      int          wc;
   } slot_t;

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] ZL = 8'h00;
`else
   localparam logic [7:0] ZL = 8'h3F;
`endif

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  dig_sel;
   logic [7:0]  led_seg;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   slot_t tbl[$];

   seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2)) dut (
      .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .dig_sel(dig_sel), .led_seg(led_seg), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] d, input logic [7:0] l, input logic f, input logic [2:0] i);
      slot_t s;
      s.dig = d; s.led = l; s.fd = f; s.idx = i;
      s.wr = 1'b0; s.wa = 2'd0; s.wd = 32'h0; s.wc = 0;
      tbl.push_back(s);
   endtask

   task automatic addw(input logic [7:0] d, input logic [7:0] l, input logic f, input logic [2:0] i,
                       input logic [1:0] wa, input logic [31:0] wd, input int wc);
      slot_t s;
      s.dig = d; s.led = l; s.fd = f; s.idx = i;
      s.wr = 1'b1; s.wa = wa; s.wd = wd; s.wc = wc;
      tbl.push_back(s);
   endtask

   // One slot: two dark cycles then four lit cycles; starts just after the previous slot's last edge
   task automatic run_slot(input slot_t s, input int n);
      for (int c = 0; c < 6; c++) begin
         if ((c >= 2) && s.wr && (s.wc == c - 2)) begin
            we = 1'b1; addr = s.wa; wdata = s.wd;
         end else begin
            we = 1'b0; addr = 2'd2;
         end
         @(negedge clk);
         if (c < 2) begin
            chk($sformatf("slot%0d_c%0d_dark_dig", n, c), {24'h0, dig_sel}, 32'h0);
            chk($sformatf("slot%0d_c%0d_dark_led", n, c), {24'h0, led_seg}, 32'h0);
            chk($sformatf("slot%0d_c%0d_frame_done", n, c), {31'h0, frame_done},
                {31'h0, (c == 0) ? s.fd : 1'b0});
            chk($sformatf("slot%0d_c%0d_status_blank", n, c), rdata, {26'h0, 2'd1, 1'b0, s.idx});
         end else begin
            chk($sformatf("slot%0d_c%0d_dig", n, c), {24'h0, dig_sel}, {24'h0, s.dig});
            chk($sformatf("slot%0d_c%0d_led", n, c), {24'h0, led_seg}, {24'h0, s.led});
            chk($sformatf("slot%0d_c%0d_frame_done", n, c), {31'h0, frame_done}, 32'h0);
            if (!we) chk($sformatf("slot%0d_c%0d_status_show", n, c), rdata, {26'h0, 2'd2, 1'b0, s.idx});
         end
         @(posedge clk); #1;
      end
      we = 1'b0; addr = 2'd2;
   endtask

   initial begin
      logic [31:0] rst_exp [3];
      int lit;
      int found;
      rst_exp[0] = 32'hDEAD_BEEF;
      rst_exp[1] = 32'h0000_00FF;
      rst_exp[2] = 32'h0000_0010;

      // Frame 1: DEADBEEF, PEND rewritten while digit 3 is lit
      add (8'h01, 8'h71, 1'b0, 3'd0);
      add (8'h02, 8'h79, 1'b0, 3'd1);
      add (8'h04, 8'h79, 1'b0, 3'd2);
      addw(8'h08, 8'h7C, 1'b0, 3'd3, 2'd0, 32'h1234_5678, 0);
      add (8'h10, 8'h5E, 1'b0, 3'd4);
      add (8'h20, 8'h77, 1'b0, 3'd5);
      add (8'h40, 8'h79, 1'b0, 3'd6);
      add (8'h80, 8'h5E, 1'b0, 3'd7);
      // Frame 2: 12345678
      add (8'h01, 8'h7F, 1'b1, 3'd0);
      add (8'h02, 8'h07, 1'b0, 3'd1);
      add (8'h04, 8'h7D, 1'b0, 3'd2);
      add (8'h08, 8'h6D, 1'b0, 3'd3);
      add (8'h10, 8'h66, 1'b0, 3'd4);
      add (8'h20, 8'h4F, 1'b0, 3'd5);
      add (8'h40, 8'h5B, 1'b0, 3'd6);
      add (8'h80, 8'h06, 1'b0, 3'd7);
      // Frame 3: still 12345678; PEND=11111111 mid-frame, then 9ABCDEF0 in the commit cycle
      add (8'h01, 8'h7F, 1'b1, 3'd0);
      add (8'h02, 8'h07, 1'b0, 3'd1);
      addw(8'h04, 8'h7D, 1'b0, 3'd2, 2'd0, 32'h1111_1111, 1);
      add (8'h08, 8'h6D, 1'b0, 3'd3);
      add (8'h10, 8'h66, 1'b0, 3'd4);
      add (8'h20, 8'h4F, 1'b0, 3'd5);
      add (8'h40, 8'h5B, 1'b0, 3'd6);
      addw(8'h80, 8'h06, 1'b0, 3'd7, 2'd0, 32'h9ABC_DEF0, 3);
      // Frame 4: 9ABCDEF0 (write-through), 00000050 in the commit cycle
      add (8'h01, 8'h3F, 1'b1, 3'd0);
      add (8'h02, 8'h71, 1'b0, 3'd1);
      add (8'h04, 8'h79, 1'b0, 3'd2);
      add (8'h08, 8'h5E, 1'b0, 3'd3);
      add (8'h10, 8'h39, 1'b0, 3'd4);
      add (8'h20, 8'h7C, 1'b0, 3'd5);
      add (8'h40, 8'h77, 1'b0, 3'd6);
      addw(8'h80, 8'h6F, 1'b0, 3'd7, 2'd0, 32'h0000_0050, 3);
      // Frame 5: 00000050, MASK=81 written during digit 6
      add (8'h01, 8'h3F, 1'b1, 3'd0);
      add (8'h02, 8'h6D, 1'b0, 3'd1);
      add (8'h04, ZL,    1'b0, 3'd2);
      add (8'h08, ZL,    1'b0, 3'd3);
      add (8'h10, ZL,    1'b0, 3'd4);
      add (8'h20, ZL,    1'b0, 3'd5);
      addw(8'h40, ZL,    1'b0, 3'd6, 2'd1, 32'h0000_0081, 0);
      add (8'h80, ZL,    1'b0, 3'd7);
      // Frame 6+: digits 0 and 7 alternate, MASK=0 in the last slot
      add (8'h01, 8'h3F, 1'b1, 3'd0);
      add (8'h80, ZL,    1'b0, 3'd7);
      add (8'h01, 8'h3F, 1'b1, 3'd0);
      addw(8'h80, ZL,    1'b0, 3'd7, 2'd1, 32'h0000_0000, 0);

      // Reset with writes attempted on every address
      rst = 1'b0; we = 1'b1; addr = 2'd0; wdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      for (int a = 0; a < 3; a++) begin
         addr = 2'(a);
         @(negedge clk);
         chk($sformatf("reset_rdata_a%0d", a), rdata, rst_exp[a]);
         chk($sformatf("reset_dig_a%0d", a), {24'h0, dig_sel}, 32'h0);
         chk($sformatf("reset_led_a%0d", a), {24'h0, led_seg}, 32'h0);
         chk($sformatf("reset_frame_done_a%0d", a), {31'h0, frame_done}, 32'h0);
         @(posedge clk); #1;
      end
      rst = 1'b1; we = 1'b0; addr = 2'd2;

      for (int n = 0; n < tbl.size(); n++) begin
         run_slot(tbl[n], n);
      end

      // MASK=0 took effect at the last slot end: OFF, dark, no frame_done
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("off_dig_%0d", k), {24'h0, dig_sel}, 32'h0);
         chk($sformatf("off_led_%0d", k), {24'h0, led_seg}, 32'h0);
         chk($sformatf("off_frame_done_%0d", k), {31'h0, frame_done}, 32'h0);
         chk($sformatf("off_state_%0d", k), {30'h0, rdata[5:4]}, 32'h0);
         @(posedge clk); #1;
      end
      we = 1'b1; addr = 2'd0; wdata = 32'h0000_0001;
      @(posedge clk); #1;
      we = 1'b1; addr = 2'd1; wdata = 32'h0000_0002;
      @(posedge clk); #1;
      we = 1'b0; addr = 2'd2;
      lit = 0;
      for (int k = 1; (k <= 20) && (lit == 0); k++) begin
         @(negedge clk);
         if (dig_sel != 8'h00) begin
            lit = k;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("off_exit_latency", lit, 32'd4);
      chk("off_exit_dig", {24'h0, dig_sel}, 32'h0000_0002);
      chk("off_exit_led", {24'h0, led_seg}, {24'h0, ZL});
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("off_exit_hold_%0d", k), {24'h0, dig_sel}, 32'h0000_0002);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_digit_wrap_fd", {31'h0, frame_done}, 32'h1);
      chk("single_digit_wrap_dark", {24'h0, dig_sel}, 32'h0);
      @(posedge clk); #1;
      we = 1'b1; addr = 2'd1; wdata = 32'h0000_00FF;
      @(posedge clk); #1;
      we = 1'b0; addr = 2'd2;

      // Reset during digit 5 with a simultaneous data write
      found = 0;
      for (int k = 0; (k < 200) && (found == 0); k++) begin
         @(negedge clk);
         if (dig_sel == 8'h20) begin
            found = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("reach_digit5", found, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b1; addr = 2'd0; wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      rst = 1'b1; we = 1'b0; addr = 2'd0;
      @(negedge clk);
      chk("midshow_rst_dig", {24'h0, dig_sel}, 32'h0);
      chk("midshow_rst_led", {24'h0, led_seg}, 32'h0);
      chk("midshow_rst_fd", {31'h0, frame_done}, 32'h0);
      chk("midshow_rst_pend", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      addr = 2'd2;
      @(negedge clk);
      chk("midshow_rst_status", rdata, 32'h0000_0010);
      @(posedge clk); #1;
      addr = 2'd1;
      @(negedge clk);
      chk("midshow_rst_digit0", {24'h0, dig_sel}, 32'h0000_0001);
      chk("midshow_rst_led0", {24'h0, led_seg}, 32'h0000_0071);
      chk("midshow_rst_mask", rdata, 32'h0000_00FF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
